float_mul_arbiter: RTL and testbench

Shares one `float_mul` instance among `N_REQ` requesters, such as calculator front-end, ALU op decoder and test port. Each requester hands over an IEEE-754 single-precision operand pair on a valid/ready handshake. The block arbitrates round-robin and drives the multiplier's `A`/`B` inputs for exactly `MUL_LAT` cycles. It captures `S`/`overflow` and returns them to the winning requester on a second valid/ready handshake. One multiply is in flight at a time.

---
 rtl/float_mul_arbiter_pkg.sv | 19 +
 rtl/float_mul_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/float_mul_arbiter.sv | 155 +++++++++++++++
 tb/tb_float_mul_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_mul_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// float_mul_arbiter_pkg
//   Shared types and constants for the float_mul sharing arbiter.
//   - state_t     : control FSM states (ST_IDLE, ST_WAIT, ST_RESP)
//   - FP_W        : IEEE-754 single-precision word width
//   - MUL_LAT_DEF : default multiplier latency in clock cycles
// -----------------------------------------------------------------------------
package float_mul_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int FP_W        = 32;
    localparam int MUL_LAT_DEF = 2;

endpackage : float_mul_arbiter_pkg

// File: rtl/float_mul_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at i_ptr and ascends
//   with wrap; the first asserted request wins.
//
//   Optional feature macro: FMUL_ARB_PRIO0_EN
//     defined   : request 0 has absolute priority; requests 1..N-1 rotate
//                 among themselves starting at i_ptr.
//     undefined : pure round-robin over all N requests.
//
//   Ports
//     i_req      [N]   request vector
//     i_ptr      [IW]  rotate pointer (search start)
//     o_grant    [N]   one-hot grant (zero when no request)
//     o_grant_id [IW]  index of the granted request
//     o_any            at least one request granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_id,
    output logic          o_any
);

    always_comb begin
        int   idx;
        logic found;
        o_grant    = '0;
        o_grant_id = '0;
        found      = 1'b0;
        idx        = 0;
`ifdef FMUL_ARB_PRIO0_EN
        if (i_req[0]) begin
            o_grant[0] = 1'b1;
            found      = 1'b1;
        end
`endif
        for (int off = 0; off < N; off++) begin
            idx = int'(i_ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
`ifdef FMUL_ARB_PRIO0_EN
            // Requester 0 was already handled above; the rotation skips it.
            if (!found && (idx != 0) && i_req[idx]) begin
`else
            if (!found && i_req[idx]) begin
`endif
                o_grant[idx] = 1'b1;
                o_grant_id   = IW'(idx);
                found        = 1'b1;
            end
        end
        o_any = found;
    end

endmodule : rr_arbiter

// File: rtl/float_mul_arbiter.sv
// -----------------------------------------------------------------------------
// float_mul_arbiter
//   Shares one float_mul instance among N_REQ requesters. An operand pair is
//   accepted on a valid/ready handshake, held on the multiplier inputs for
//   MUL_LAT cycles, and the captured product/overflow is returned to the
//   winner on a second valid/ready handshake. One multiply in flight.
//
//   Optional feature macro: FMUL_ARB_PRIO0_EN (requester 0 absolute priority;
//   a grant to requester 0 does not move the rotate pointer).
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     i_req_valid/o_req_ready    [N_REQ] operand handshake (ready one-hot)
//     i_req_a, i_req_b           [32*N_REQ] packed operands, slot i = [32i+:32]
//     o_rsp_valid/i_rsp_ready    [N_REQ] result handshake (valid one-hot)
//     o_rsp_data, o_rsp_overflow captured product and overflow flag
//     o_mul_a, o_mul_b           multiplier A/B inputs
//     i_mul_s, i_mul_overflow    multiplier S/overflow outputs
//     o_busy                     high outside IDLE
//     o_grant_id                 index of the current/last winner
// -----------------------------------------------------------------------------
module float_mul_arbiter
    import float_mul_arbiter_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int MUL_LAT = MUL_LAT_DEF,
    localparam int IW      = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      i_req_valid,
    output logic [N_REQ-1:0]      o_req_ready,
    input  logic [FP_W*N_REQ-1:0] i_req_a,
    input  logic [FP_W*N_REQ-1:0] i_req_b,
    output logic [N_REQ-1:0]      o_rsp_valid,
    input  logic [N_REQ-1:0]      i_rsp_ready,
    output logic [FP_W-1:0]       o_rsp_data,
    output logic                  o_rsp_overflow,
    output logic [FP_W-1:0]       o_mul_a,
    output logic [FP_W-1:0]       o_mul_b,
    input  logic [FP_W-1:0]       i_mul_s,
    input  logic                  i_mul_overflow,
    output logic                  o_busy,
    output logic [IW-1:0]         o_grant_id
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t            r_state;
    logic [IW-1:0]     r_ptr;
    logic [CW-1:0]     r_cnt;
    logic [FP_W-1:0]   r_mul_a;
    logic [FP_W-1:0]   r_mul_b;
    logic [FP_W-1:0]   r_rsp_data;
    logic              r_rsp_overflow;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [IW-1:0]     r_grant_id;

    logic [N_REQ-1:0]  w_grant;
    logic [IW-1:0]     w_gid;
    logic              w_any;
    logic [IW-1:0]     w_ptr_next;
    logic [FP_W-1:0]   w_op_a [N_REQ];
    logic [FP_W-1:0]   w_op_b [N_REQ];

    // Unpack the operand buses into per-requester words.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_op_a[gi] = i_req_a[gi*FP_W +: FP_W];
        assign w_op_b[gi] = i_req_b[gi*FP_W +: FP_W];
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .i_req      (i_req_valid),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_gid),
        .o_any      (w_any)
    );

    // Pointer after the current winner, wrapping at N_REQ.
    always_comb begin
        if (r_grant_id == IW'(N_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_grant_id + 1'b1;
        end
`ifdef FMUL_ARB_PRIO0_EN
        // Requester 0 sits outside the rotation, so serving it leaves the
        // pointer where it was.
        if (r_grant_id == '0) begin
            w_ptr_next = r_ptr;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_rsp_data     <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_valid    <= '0;
            r_grant_id     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The grant is the ready vector, so any grant is a transfer.
                    if (w_any) begin
                        r_mul_a    <= w_op_a[w_gid];
                        r_mul_b    <= w_op_b[w_gid];
                        r_grant_id <= w_gid;
                        r_cnt      <= CW'(MUL_LAT - 1);
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data     <= i_mul_s;
                        r_rsp_overflow <= i_mul_overflow;
                        r_rsp_valid    <= {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;
                        r_state        <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready[r_grant_id]) begin
                        r_rsp_valid <= '0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is forced low while reset is asserted, independent of state.
    assign o_req_ready    = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_mul_a        = r_mul_a;
    assign o_mul_b        = r_mul_b;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_grant_id     = r_grant_id;

endmodule : float_mul_arbiter

// File: tb/tb_float_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_float_mul_arbiter
//   Directed bench for float_mul_arbiter (N_REQ=4, MUL_LAT=2). The multiplier
//   is a behavioural stand-in: a table of hand-computed IEEE-754 products,
//   presented MUL_LAT cycles after the operands settle. Honours
//   FMUL_ARB_PRIO0_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_float_mul_arbiter;

    localparam int N = 4;
    localparam int L = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_overflow;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic [31:0]   mul_s;
    logic          mul_overflow;
    logic          busy;
    logic [1:0]    grant_id;

    int checks   = 0;
    int failures = 0;

    float_mul_arbiter #(
        .N_REQ   (N),
        .MUL_LAT (L)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_overflow (rsp_overflow),
        .o_mul_a        (mul_a),
        .o_mul_b        (mul_b),
        .i_mul_s        (mul_s),
        .i_mul_overflow (mul_overflow),
        .o_busy         (busy),
        .o_grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: {overflow, product}. Table entries are the
    // hand-computed products; other pairs get an arbitrary deterministic word.
    function automatic logic [32:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return {1'b0, 32'h40C00000}; // 2.0*3.0
            {32'h3FC00000, 32'h3FC00000}: return {1'b0, 32'h40100000}; // 1.5*1.5
            {32'h7F000000, 32'h7F000000}: return {1'b1, 32'h7F800000}; // overflow
            default:                      return {1'b0, a ^ {b[15:0], b[31:16]}};
        endcase
    endfunction

    // With MUL_LAT=2 the result must be valid at the second edge after the
    // operands change: one register stage followed by the table lookup.
    logic [31:0] d_a = '0;
    logic [31:0] d_b = '0;
    always @(posedge clk) begin
        d_a <= mul_a;
        d_b <= mul_b;
    end
    logic [32:0] model_out;
    assign model_out    = fmul_model(d_a, d_b);
    assign mul_s        = model_out[31:0];
    assign mul_overflow = model_out[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_s(input logic [N-1:0] v);
        logic [32:0] r;
        int k;
        k = oh_idx(v);
        r = fmul_model(req_a[k*32 +: 32], req_b[k*32 +: 32]);
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_ov(input logic [N-1:0] v);
        logic [32:0] r;
        int k;
        k = oh_idx(v);
        r = fmul_model(req_a[k*32 +: 32], req_b[k*32 +: 32]);
        return {31'b0, r[32]};
    endfunction

    // Accept log and response scoreboard (operands stay stable from accept
    // to response, so the requester's slot still holds them).
    int cyc   = 0;
    int acc_n = 0;
    int acc_id  [64];
    int acc_cyc [64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && ((req_valid & req_ready) != '0) && (acc_n < 64)) begin
            acc_id[acc_n]  <= oh_idx(req_valid & req_ready);
            acc_cyc[acc_n] <= cyc;
            acc_n          <= acc_n + 1;
        end
        if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
            chk("sb_data", rsp_data, exp_s(rsp_valid));
            chk("sb_ovf", {31'b0, rsp_overflow}, exp_ov(rsp_valid));
            chk("sb_onehot", {28'b0, rsp_valid}, 32'(1 << grant_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, {28'b0, req_ready}, 32'h0);
        chk({tag, "_rsp_valid"}, {28'b0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_data"},  rsp_data, 32'h0);
        chk({tag, "_rsp_ovf"},   {31'b0, rsp_overflow}, 32'h0);
        chk({tag, "_mul_a"},     mul_a, 32'h0);
        chk({tag, "_mul_b"},     mul_b, 32'h0);
        chk({tag, "_busy"},      {31'b0, busy}, 32'h0);
        chk({tag, "_grant_id"},  {30'b0, grant_id}, 32'h0);
    endtask

    // One complete operation for requester idx with rsp_ready already high.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] es, input logic eov);
        int n;
        int lat;
        set_op(idx, a, b);
        req_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 50) begin
            tick();
            n++;
        end
        chk("op_ready_timeout", {31'b0, n < 50}, 32'h1);
        chk("op_ready_onehot", {28'b0, req_ready}, 32'(1 << idx));
        tick();                       // accept edge
        req_valid[idx] = 1'b0;
        chk("op_mul_a", mul_a, a);
        chk("op_mul_b", mul_b, b);
        chk("op_grant_id", {30'b0, grant_id}, 32'(idx));
        chk("op_busy", {31'b0, busy}, 32'h1);
        chk("op_ready_wait", {28'b0, req_ready}, 32'h0);
        // Count cycles with the accept cycle as the first one.
        lat = 1;
        while (rsp_valid == '0 && lat < 50) begin
            tick();
            lat++;
        end
        chk("op_latency", 32'(lat), 32'(L + 1));
        chk("op_rsp_valid", {28'b0, rsp_valid}, 32'(1 << idx));
        chk("op_rsp_data", rsp_data, es);
        chk("op_rsp_ovf", {31'b0, rsp_overflow}, {31'b0, eov});
        tick();                       // response handshake
        chk("op_rsp_clear", {28'b0, rsp_valid}, 32'h0);
        chk("op_idle", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int n;
        int start;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with every requester valid to show ready is forced low.
        chk_reset_vals("rst");
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single op: requester 1, 2.0 * 3.0.
        run_op(1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
        // Overflow: requester 3.
        run_op(3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);

        // Fairness: all four valid continuously, pointer is back at 0.
        for (int i = 0; i < N; i++) begin
            set_op(i, 32'h3F800000 + (i << 20), 32'h40000000 + i);
        end
        start     = acc_n;
        req_valid = '1;
        n = 0;
        while (acc_n < start + 5 && n < 100) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk("fair_timeout", {31'b0, n < 100}, 32'h1);
        for (int i = 0; i < 5; i++) begin
`ifdef FMUL_ARB_PRIO0_EN
            chk("fair_order", 32'(acc_id[start + i]), 32'h0);
`else
            chk("fair_order", 32'(acc_id[start + i]), 32'(i % N));
`endif
        end
        for (int i = 0; i < 4; i++) begin
            chk("fair_period", 32'(acc_cyc[start + i + 1] - acc_cyc[start + i]), 32'(L + 2));
        end
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("fair_drain", {31'b0, busy}, 32'h0);

        // Backpressure: requester 2, 1.5 * 1.5, held for 10 cycles while
        // requester 3 waits and other rsp_ready bits are high.
        set_op(2, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'b0100;
        #1;
        n = 0;
        while (!req_ready[2] && n < 50) begin
            tick();
            n++;
        end
        chk("bp_ready", {28'b0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        set_op(3, 32'h41200000, 32'h3F000000);
        req_valid[3] = 1'b1;
        rsp_ready    = 4'b1011;
        n = 0;
        while (rsp_valid == '0 && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", {28'b0, rsp_valid}, 32'h4);
            chk("bp_rsp_data", rsp_data, 32'h40100000);
            chk("bp_req_ready", {28'b0, req_ready}, 32'h0);
            chk("bp_busy", {31'b0, busy}, 32'h1);
            tick();
        end
        rsp_ready = '1;
        tick();
        // Pointer now 3, requester 3 was waiting.
        chk("bp_next_grant", {28'b0, req_ready}, 32'h8);
        tick();
        req_valid = '0;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("bp_drain", {31'b0, busy}, 32'h0);

        // Move the pointer to 3, then abort an operation by reset in WAIT.
        run_op(2, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0);
        set_op(1, 32'h40000000, 32'h40400000);
        req_valid = 4'b0010;
        #1;
        chk("rw_ready", {28'b0, req_ready}, 32'h2);
        tick();                       // accept
        req_valid = '0;
        chk("rw_busy", {31'b0, busy}, 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rw");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rw_no_rsp", {28'b0, rsp_valid}, 32'h0);
            chk("rw_idle", {31'b0, busy}, 32'h0);
        end
        // Pointer restarted at 0: requester 1 beats requester 3.
        set_op(3, 32'h40800000, 32'h3E800000);
        req_valid = 4'b1010;
        #1;
        chk("rw_ptr0", {28'b0, req_ready}, 32'h2);
        run_op(1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_float_mul_arbiter
